// File: rtl/padding_window_reader.sv
// padding_window_reader: walks a 3x3 window across three padded RGB rows
// held stable on the input buses and streams one window per cycle over a
// valid/ready handshake. Tracks the output row index and flags frame end.
module padding_window_reader #(
  parameter int PIX_W    = 8,
  parameter int ROW_PIX  = 418,
  parameter int OUT_ROWS = 416
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     rows_start,
  input  logic [ROW_PIX*PIX_W-1:0] R_row0,
  input  logic [ROW_PIX*PIX_W-1:0] G_row0,
  input  logic [ROW_PIX*PIX_W-1:0] B_row0,
  input  logic [ROW_PIX*PIX_W-1:0] R_row1,
  input  logic [ROW_PIX*PIX_W-1:0] G_row1,
  input  logic [ROW_PIX*PIX_W-1:0] B_row1,
  input  logic [ROW_PIX*PIX_W-1:0] R_row2,
  input  logic [ROW_PIX*PIX_W-1:0] G_row2,
  input  logic [ROW_PIX*PIX_W-1:0] B_row2,
  output logic                     win_valid,
  input  logic                     win_ready,
  output logic [9*PIX_W-1:0]       win_R,
  output logic [9*PIX_W-1:0]       win_G,
  output logic [9*PIX_W-1:0]       win_B,
  output logic [8:0]               win_col,
  output logic [8:0]               row_idx,
  output logic                     rows_done,
  output logic                     frame_done,
  output logic                     busy
);

  localparam logic [8:0] LAST_COL = 9'(ROW_PIX - 3);
  localparam logic [8:0] LAST_ROW = 9'(OUT_ROWS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t             state;
  logic [8:0]         load_col;
  logic [9*PIX_W-1:0] nxt_R, nxt_G, nxt_B;

  // Gather the 3x3 window starting at column col from three row buses.
  function automatic logic [9*PIX_W-1:0] pick(
    input logic [ROW_PIX*PIX_W-1:0] r0,
    input logic [ROW_PIX*PIX_W-1:0] r1,
    input logic [ROW_PIX*PIX_W-1:0] r2,
    input logic [8:0]               col
  );
    logic [9*PIX_W-1:0] w;
    int unsigned        idx;
    w = '0;
    for (int unsigned c = 0; c < 3; c++) begin
      idx = 32'(col) + c;
      w[PIX_W*c     +: PIX_W] = r0[PIX_W*idx +: PIX_W];
      w[PIX_W*(3+c) +: PIX_W] = r1[PIX_W*idx +: PIX_W];
      w[PIX_W*(6+c) +: PIX_W] = r2[PIX_W*idx +: PIX_W];
    end
    return w;
  endfunction

  // Column to load on the next load event: 0 on start, else the next column.
  always_comb begin
    load_col = (state == IDLE) ? '0 : win_col + 9'd1;
    nxt_R    = pick(R_row0, R_row1, R_row2, load_col);
    nxt_G    = pick(G_row0, G_row1, G_row2, load_col);
    nxt_B    = pick(B_row0, B_row1, B_row2, load_col);
  end

  // Control FSM with registered window, handshake and row/frame bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      win_valid  <= 1'b0;
      win_R      <= '0;
      win_G      <= '0;
      win_B      <= '0;
      win_col    <= '0;
      row_idx    <= '0;
      rows_done  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rows_done  <= 1'b0;
          frame_done <= 1'b0;
          if (rows_start) begin
            state     <= STREAM;
            win_valid <= 1'b1;
            busy      <= 1'b1;
            win_col   <= '0;
            win_R     <= nxt_R;
            win_G     <= nxt_G;
            win_B     <= nxt_B;
          end
        end
        STREAM: begin
          if (win_ready) begin
            if (win_col == LAST_COL) begin
              state     <= DONE;
              win_valid <= 1'b0;
              rows_done <= 1'b1;
              if (row_idx == LAST_ROW) begin
                frame_done <= 1'b1;
                row_idx    <= '0;
              end else begin
                row_idx <= row_idx + 9'd1;
              end
            end else begin
              win_col <= load_col;
              win_R   <= nxt_R;
              win_G   <= nxt_G;
              win_B   <= nxt_B;
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          rows_done  <= 1'b0;
          frame_done <= 1'b0;
          busy       <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          win_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_padding_window_reader.sv
// Directed bench for padding_window_reader: reset, streaming, backpressure,
// ignored starts, frame wrap (OUT_ROWS=4) and mid-stream reset.
module tb_padding_window_reader;

  localparam int PW = 8;
  localparam int RP = 418;
  localparam int NCOL = RP - 2;

  logic clk = 1'b0;
  logic reset_n;
  logic rows_start;
  logic [RP*PW-1:0] R_row0, G_row0, B_row0, R_row1, G_row1, B_row1, R_row2, G_row2, B_row2;
  logic win_valid, win_ready;
  logic [9*PW-1:0] win_R, win_G, win_B;
  logic [8:0] win_col, row_idx;
  logic rows_done, frame_done, busy;

  int tests = 0;
  int fails = 0;

  padding_window_reader #(.PIX_W(PW), .ROW_PIX(RP), .OUT_ROWS(4)) dut (
    .clk(clk), .reset_n(reset_n), .rows_start(rows_start),
    .R_row0(R_row0), .G_row0(G_row0), .B_row0(B_row0),
    .R_row1(R_row1), .G_row1(G_row1), .B_row1(B_row1),
    .R_row2(R_row2), .G_row2(G_row2), .B_row2(B_row2),
    .win_valid(win_valid), .win_ready(win_ready),
    .win_R(win_R), .win_G(win_G), .win_B(win_B),
    .win_col(win_col), .row_idx(row_idx),
    .rows_done(rows_done), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Pixel pattern: ch 0=R, 1=G, 2=B.
  function automatic logic [7:0] pix(input int ch, input int r, input int j);
    case (ch)
      0:       return 8'((j + r) % 256);
      1:       return 8'((2 * j + r) % 256);
      default: return 8'(255 - (j % 256));
    endcase
  endfunction

  function automatic logic [71:0] exp_win(input int ch, input int col);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[8*(3*r+c) +: 8] = pix(ch, r, col + c);
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, 72'(win_valid), 72'(0));
    chk({tag, "_R"}, win_R, 72'(0));
    chk({tag, "_G"}, win_G, 72'(0));
    chk({tag, "_B"}, win_B, 72'(0));
    chk({tag, "_col"}, 72'(win_col), 72'(0));
    chk({tag, "_row"}, 72'(row_idx), 72'(0));
    chk({tag, "_rdone"}, 72'(rows_done), 72'(0));
    chk({tag, "_fdone"}, 72'(frame_done), 72'(0));
    chk({tag, "_busy"}, 72'(busy), 72'(0));
  endtask

  // mode 0: ready always 1; 1: random ready; 2: ready 1 with stray starts.
  task automatic run_set(input int mode, input int row_before);
    int xfers, cyc, exp_col, row_after;
    logic [71:0] pr, pg, pb;
    logic [8:0] pcol;
    logic stalled;
    row_after = (row_before == 3) ? 0 : row_before + 1;
    chk("pre_row_idx", 72'(row_idx), 72'(row_before));
    rows_start = 1'b1;
    step();
    rows_start = 1'b0;
    chk("start_busy", 72'(busy), 72'(1));
    xfers = 0; cyc = 0; exp_col = 0; stalled = 1'b0;
    pr = '0; pg = '0; pb = '0; pcol = '0;
    while (xfers < NCOL && cyc < 4000) begin
      chk("valid", 72'(win_valid), 72'(1));
      chk("col", 72'(win_col), 72'(exp_col));
      chk("win_R", win_R, exp_win(0, exp_col));
      chk("win_G", win_G, exp_win(1, exp_col));
      chk("win_B", win_B, exp_win(2, exp_col));
      chk("rdone_low", 72'(rows_done), 72'(0));
      if (exp_col == 5) chk("col5_R_1_2", 72'(win_R[8*5 +: 8]), 72'(8));
      if (stalled) begin
        chk("hold_col", 72'(win_col), 72'(pcol));
        chk("hold_R", win_R, pr);
        chk("hold_G", win_G, pg);
        chk("hold_B", win_B, pb);
      end
      win_ready  = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      rows_start = (mode == 2 && exp_col == 100) ? 1'b1 : 1'b0;
      pr = win_R; pg = win_G; pb = win_B; pcol = win_col;
      stalled = !win_ready;
      if (win_ready) begin
        xfers++;
        exp_col++;
      end
      cyc++;
      step();
      rows_start = 1'b0;
    end
    chk("xfer_count", 72'(xfers), 72'(NCOL));
    chk("done_valid", 72'(win_valid), 72'(0));
    chk("done_rdone", 72'(rows_done), 72'(1));
    chk("done_fdone", 72'(frame_done), 72'(row_before == 3));
    chk("done_row_idx", 72'(row_idx), 72'(row_after));
    chk("done_busy", 72'(busy), 72'(1));
    if (mode == 2) rows_start = 1'b1;
    step();
    rows_start = 1'b0;
    chk("idle_busy", 72'(busy), 72'(0));
    chk("idle_valid", 72'(win_valid), 72'(0));
    chk("idle_rdone", 72'(rows_done), 72'(0));
    chk("idle_fdone", 72'(frame_done), 72'(0));
    if (mode == 2) begin
      step();
      chk("no_restart_valid", 72'(win_valid), 72'(0));
      chk("no_restart_busy", 72'(busy), 72'(0));
    end
  endtask

  initial begin
    int cyc;
    for (int j = 0; j < RP; j++) begin
      R_row0[8*j +: 8] = pix(0, 0, j); R_row1[8*j +: 8] = pix(0, 1, j); R_row2[8*j +: 8] = pix(0, 2, j);
      G_row0[8*j +: 8] = pix(1, 0, j); G_row1[8*j +: 8] = pix(1, 1, j); G_row2[8*j +: 8] = pix(1, 2, j);
      B_row0[8*j +: 8] = pix(2, 0, j); B_row1[8*j +: 8] = pix(2, 1, j); B_row2[8*j +: 8] = pix(2, 2, j);
    end

    // Reset with random control inputs.
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rows_start = 1'($urandom_range(0, 1));
      win_ready  = 1'($urandom_range(0, 1));
      step();
    end
    chk_zero_outputs("reset");
    reset_n = 1'b1;
    rows_start = 1'b0;
    win_ready = 1'b1;
    step();
    step();
    chk_zero_outputs("post_reset");

    run_set(0, 0);   // streaming, row_idx 0 -> 1
    run_set(1, 1);   // backpressure
    run_set(2, 2);   // ignored starts
    run_set(0, 3);   // frame wrap
    run_set(0, 0);
    run_set(0, 1);

    // Mid-stream reset at column 200 of row set 2.
    chk("mid_pre_row", 72'(row_idx), 72'(2));
    rows_start = 1'b1;
    step();
    rows_start = 1'b0;
    win_ready = 1'b1;
    cyc = 0;
    while (win_col != 9'd200 && cyc < 300) begin
      step();
      cyc++;
    end
    chk("mid_reached_200", 72'(win_col), 72'(200));
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk_zero_outputs("mid_reset");
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_no_rdone", 72'(rows_done), 72'(0));
      chk("mid_no_valid", 72'(win_valid), 72'(0));
    end
    rows_start = 1'b1;
    step();
    rows_start = 1'b0;
    chk("restart_valid", 72'(win_valid), 72'(1));
    chk("restart_col", 72'(win_col), 72'(0));
    chk("restart_row", 72'(row_idx), 72'(0));
    chk("restart_R", win_R, exp_win(0, 0));
    chk("restart_busy", 72'(busy), 72'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
